// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, FSM state type and latency bound for dmem_ctrl.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for RV32 loads/stores.
// Produces store byte enables and replicated write data, extracts and extends
// load data, and flags illegal funct3. When DMEM_MISALIGN_TRAP_EN is defined
// misaligned half/word accesses are flagged; otherwise the flag stays low and
// the low address bits are forced to alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Effective lane offset: halves drop addr[0], words always start at lane 0.
    always_comb begin
        off = addr;
        case (funct3[1:0])
            2'b01:   off = {addr[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = addr;
        endcase
    end

    // Store enables and data replicated across all lanes.
    always_comb begin
        byte_en  = 4'b0000;
        wdata_al = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << off;
                wdata_al = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = 4'b0011 << off;
                wdata_al = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                wdata_al = wdata;
            end
            default: begin
                byte_en  = 4'b0000;
                wdata_al = wdata;
            end
        endcase
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        shifted = raw >> {off, 3'b000};
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'h000000, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'h0000, shifted[15:0]};
            F3_W:    rdata = raw;
            default: rdata = '0;
        endcase
    end

    // Fault classification: illegal funct3 and (optionally) misalignment.
    always_comb begin
        if (we) begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                        funct3 == F3_BU || funct3 == F3_HU);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed RV32 data memory behind a valid/ready
// request/response handshake with LATENCY-cycle access delay.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word -> error).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_SIZE_KB = 1,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned     DEPTH    = MEM_SIZE_KB * 256;
    localparam int unsigned     IDX_W    = $clog2(DEPTH);
    localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);
    localparam int unsigned     CNT_W    = $clog2(LATENCY_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       f3_q;

    logic [31:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             oor;
    logic [31:0]      raw;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_al;
    logic [31:0]      load_data;
    logic             misaligned;
    logic             illegal;
    logic             fault;
    logic             commit;

    // Address decode and access-time control derived from the captured request.
    always_comb begin
        idx    = addr_q[IDX_W+1:2];
        oor    = addr_q[31:2] >= DEPTH_W;
        raw    = mem[idx];
        fault  = illegal || misaligned || oor;
        commit = (state == WAIT) && (cnt == '0);
    end

    dmem_lane_align u_align (
        .addr       (addr_q[1:0]),
        .we         (we_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .raw        (raw),
        .byte_en    (byte_en),
        .wdata_al   (wdata_al),
        .rdata      (load_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // Memory array: per-byte write at the commit edge; never reset.
    always_ff @(posedge clk) begin
        if (commit && we_q && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: capture, latency countdown, response hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        f3_q      <= req_funct3;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_err   <= fault;
                        rsp_rdata <= (we_q || fault) ? '0 : load_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl.
// dut1 uses LATENCY=1, dut3 uses LATENCY=3; both MEM_SIZE_KB=1.
module tb_dmem_ctrl;

    logic clk;
    int   checks;
    int   errors;

    logic        rst1, req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic [2:0]  req_funct3_1;

    logic        rst3, req_valid3, req_ready3, req_we3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [31:0] req_addr3, req_wdata3, rsp_rdata3;
    logic [2:0]  req_funct3_3;

    dmem_ctrl #(.MEM_SIZE_KB(1), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .req_funct3(req_funct3_1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    dmem_ctrl #(.MEM_SIZE_KB(1), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .req_funct3(req_funct3_3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction on dut1; called at posedge+1. Inputs are scrambled after
    // acceptance so that a design which fails to capture them is exposed.
    task automatic xact1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                         output int lat);
        int n;
        req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata; req_funct3_1 = f3;
        n = 0;
        while (!req_ready1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid1 = 1'b0; req_we1 = ~we; req_addr1 = 32'h0000_0000;
        req_wdata1 = ~wdata; req_funct3_1 = 3'b111;
        lat = 0;
        while (!rsp_valid1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata = rsp_rdata1;
        err   = rsp_err1;
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready1); end
        checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid1); end
        checks++; if (rsp_rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata1); end
        checks++; if (rsp_err1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err1); end
    endtask

    task automatic test_word();
        logic [31:0] d; logic e; int l;
        xact1(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, d, e, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", l); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 00000000", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", e); end
        xact1(1'b0, 32'h10, 32'h0, 3'b010, d, e, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL lw_latency got %0d exp 1", l); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", e); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic e; int l;
        xact1(1'b1, 32'h20, 32'h0000_0000, 3'b010, d, e, l);
        xact1(1'b1, 32'h21, 32'h1234_5680, 3'b000, d, e, l);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", e); end
        xact1(1'b0, 32'h21, 32'h0, 3'b000, d, e, l);
        checks++; if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", d); end
        xact1(1'b0, 32'h21, 32'h0, 3'b100, d, e, l);
        checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", d); end
        xact1(1'b0, 32'h20, 32'h0, 3'b010, d, e, l);
        checks++; if (d !== 32'h0000_8000) begin errors++; $display("FAIL sb_word got %h exp 00008000", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic e; int l;
        xact1(1'b1, 32'h40, 32'h1234_5678, 3'b010, d, e, l);
        xact1(1'b1, 32'h42, 32'hFFFF_A5A5, 3'b001, d, e, l);
        xact1(1'b0, 32'h42, 32'h0, 3'b001, d, e, l);
        checks++; if (d !== 32'hFFFF_A5A5) begin errors++; $display("FAIL lh_rdata got %h exp ffffa5a5", d); end
        xact1(1'b0, 32'h42, 32'h0, 3'b101, d, e, l);
        checks++; if (d !== 32'h0000_A5A5) begin errors++; $display("FAIL lhu_rdata got %h exp 0000a5a5", d); end
        xact1(1'b0, 32'h40, 32'h0, 3'b010, d, e, l);
        checks++; if (d !== 32'hA5A5_5678) begin errors++; $display("FAIL sh_word got %h exp a5a55678", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int l;
        xact1(1'b0, 32'h402, 32'h0, 3'b010, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", d); end
        xact1(1'b0, 32'h12, 32'h0, 3'b010, d, e, l);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misalign_rdata got %h exp 0", d); end
`else
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL misalign_err got %b exp 0", e); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_rdata got %h exp deadbeef", d); end
`endif
        xact1(1'b0, 32'h10, 32'h0, 3'b011, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL f3_011_err got %b exp 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL f3_011_rdata got %h exp 0", d); end
        xact1(1'b1, 32'h10, 32'h0000_0000, 3'b100, d, e, l);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL st_f3_100_err got %b exp 1", e); end
        xact1(1'b0, 32'h10, 32'h0, 3'b010, d, e, l);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_store_nowrite got %h exp deadbeef", d); end
    endtask

    task automatic test_latency();
        int n;
        logic bad_ready, bad_hold;
        // Seed a word through dut3.
        req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 32'h4; req_wdata3 = 32'hCAFE_F00D; req_funct3_3 = 3'b010;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        n = 0;
        while (!rsp_valid3 && n < 20) begin @(posedge clk); #1; n++; end
        rsp_ready3 = 1'b1; @(posedge clk); #1; rsp_ready3 = 1'b0;
        // Load with the consumer stalled.
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h4; req_funct3_3 = 3'b010;
        @(posedge clk); #1;
        req_valid3 = 1'b0; req_addr3 = 32'h0; req_we3 = 1'b1;
        n = 0; bad_ready = 1'b0;
        while (!rsp_valid3 && n < 20) begin
            if (req_ready3 !== 1'b0) bad_ready = 1'b1;
            @(posedge clk); #1; n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL lat3_cycles got %0d exp 3", n); end
        checks++; if (rsp_rdata3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat3_rdata got %h exp cafef00d", rsp_rdata3); end
        bad_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready3 !== 1'b0) bad_ready = 1'b1;
            if (rsp_valid3 !== 1'b1 || rsp_rdata3 !== 32'hCAFE_F00D || rsp_err3 !== 1'b0) bad_hold = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (bad_ready !== 1'b0) begin errors++; $display("FAIL lat3_req_ready_low got %b exp 0", bad_ready); end
        checks++; if (bad_hold !== 1'b0) begin errors++; $display("FAIL lat3_hold_stable got %b exp 0", bad_hold); end
        rsp_ready3 = 1'b1; @(posedge clk); #1; rsp_ready3 = 1'b0;
        checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_rsp_drop got %b exp 0", rsp_valid3); end
        checks++; if (req_ready3 !== 1'b1) begin errors++; $display("FAIL lat3_ready_back got %b exp 1", req_ready3); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int l;
        xact1(1'b1, 32'h8, 32'h1111_1111, 3'b010, d, e, l);
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'h2222_2222; req_funct3_1 = 3'b010;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        #1 rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b exp 1", req_ready1); end
        checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid got %b exp 0", rsp_valid1); end
        @(posedge clk); #1;
        xact1(1'b0, 32'h8, 32'h0, 3'b010, d, e, l);
        checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL rstmid_word got %h exp 11111111", d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst1 = 1'b1; req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_funct3_1 = '0; rsp_ready1 = 1'b0;
        rst3 = 1'b1; req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; req_funct3_3 = '0; rsp_ready3 = 1'b0;
        #12;
        rst1 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_latency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, byte-addressed RV32 data memory with a valid/ready request-response handshake and configurable access latency.
- Supports all RV32I load/store widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Stores use per-byte write enables (read-modify-write is never needed).
- Reports out-of-range, misaligned and illegal-funct3 accesses on an error flag.
- Sits between the MEM pipeline stage and the data RAM; a stalling core waits on req_ready/rsp_valid.

Parameters:
- MEM_SIZE_KB, 1, memory size in KiB; depth = MEM_SIZE_KB*256 words of 32 bits.
- LATENCY, 1, request-acceptance-to-response delay in cycles; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half/word is used according to funct3.
- req_funct3  in  3  RV32I load/store funct3.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  access faulted.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, cnt=0.
- Reset does not clear memory contents.
- Address decode:
  - word index = req_addr[31:2];
  - byte lane = req_addr[1:0];
  - out of range when word index >= depth.
- Request capture: on acceptance (req_valid && req_ready), addr, we, wdata and funct3 are registered. Input changes after acceptance have no effect.
- FSM states:
  - IDLE: on acceptance, go to WAIT and load cnt=LATENCY-1.
  - WAIT: if cnt!=0, decrement; if cnt==0, perform the access at that edge, register rsp_rdata/rsp_err, and go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE; req_ready rises the next cycle, so there is no same-cycle turnaround.
- Latency: a request accepted at edge E0 gives rsp_valid visible after edge E0+LATENCY. A store is committed at that same edge.
- Back-pressure: in RESP, rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
- Store byte enables (lane offset = addr[1:0]):
  - SB: 1 enable at the lane, data = wdata[7:0] replicated.
  - SH: 2 enables at lanes {addr[1],0}, data = wdata[15:0] replicated.
  - SW: all 4 enables, data = wdata.
- Load extraction: selected byte/half placed at bits [7:0]/[15:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word.
- Errors (rsp_err=1, rsp_rdata=0, no memory write):
  - illegal funct3: store with funct3 not in {000,001,010}; load with funct3 not in {000,001,010,100,101};
  - address out of range;
  - misalignment, only when DMEM_MISALIGN_TRAP_EN is defined.
- Store response: rsp_rdata=0.
- Reset mid-operation: a store not yet committed is dropped; a committed store persists; the FSM returns to IDLE.
- Load after store to the same word: the load issues only after the store's response, so it always sees the new data.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, yields rsp_err=1, no write and rsp_rdata=0.
- Undefined: misaligned low address bits are forced to alignment (half: addr[0] treated as 0; word: addr[1:0] treated as 00). The access completes with rsp_err=0.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum dmem_state_t {IDLE, WAIT, RESP};
  - LATENCY_MAX=4.
- Sub-module dmem_lane_align (combinational):
  - inputs: addr[1:0], funct3, wdata, raw read word;
  - outputs: byte_en[3:0], aligned write data, extracted/extended load data, misaligned flag, illegal flag.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid one cycle after each acceptance; rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x21 onto word 0x00000000, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0x00008000.
- SH 0xA5A5 @0x42, then LH @0x42 -> 0xFFFFA5A5; LHU -> 0x0000A5A5; lower half @0x40 unchanged.
- LATENCY=3, rsp_ready held low 5 cycles -> rsp_valid rises 3 cycles after acceptance; data held stable; req_ready=0 throughout.
- LW @0x402 with MEM_SIZE_KB=1: with the macro, err=1 and rdata=0; without it, err=1 because 0x400 is out of range. LW @0x12 without the macro -> returns word @0x10, err=0.
- funct3=011 load -> err=1. Assert rst during WAIT of an SW @0x8 -> word @0x8 unchanged and req_ready=1 after reset.
